// File: rtl/step_input_conditioner_pkg.sv
// Shared state encoding and default timing constants for the step input conditioner.
// Package name step_cond_pkg; the optional auto-repeat is enabled by STEP_AUTOREPEAT_EN.
package step_cond_pkg;

    typedef logic [1:0] step_state_t;

    localparam step_state_t IDLE       = 2'b00;
    localparam step_state_t CONFIRM_HI = 2'b01;
    localparam step_state_t PRESSED    = 2'b10;
    localparam step_state_t CONFIRM_LO = 2'b11;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_HOLD_CYCLES     = 16;
    localparam int unsigned DEF_REPEAT_CYCLES   = 8;

    // Both confirm states share bit 0, which is what drives the busy LED.
    function automatic logic is_confirm(step_state_t s);
        return s[0];
    endfunction

    // Debounced level is high once a press is accepted, until its release is confirmed.
    function automatic logic is_held(step_state_t s);
        return s[1];
    endfunction

endpackage

// File: rtl/step_input_conditioner_if.sv
// Button-side and counter-side signals of the step input conditioner.
// The master drives the raw button and mode; the conditioner (slave) returns x/stable/busy.
interface step_input_conditioner_if;

    logic btn_raw;
    logic pulse_mode;
    logic x;
    logic stable;
    logic busy;

    modport master (
        output btn_raw,
        output pulse_mode,
        input  x,
        input  stable,
        input  busy
    );

    modport slave (
        input  btn_raw,
        input  pulse_mode,
        output x,
        output stable,
        output busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; both flops reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/step_input_conditioner.sv
// Synchronise and debounce a bouncing button, then drive the counter's enable x as a pulse or level.
// Define STEP_AUTOREPEAT_EN to add hold-to-repeat pulses in pulse mode.
module step_input_conditioner
    import step_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input logic                     clk,
    input logic                     rst_n,
    step_input_conditioner_if.slave bus
);

    localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            btn_sync;
    step_state_t     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            stable_q, stable_d;
    logic            x_q, x_d;
    logic            press_accept;
    logic            repeat_fire;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.btn_raw),
        .q_o   (btn_sync)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        press_accept = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d = CONFIRM_HI;
                    cnt_d   = '0;
                end
            end
            CONFIRM_HI: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                end else if (cnt_q == CntLast) begin
                    state_d      = PRESSED;
                    press_accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_d = CONFIRM_LO;
                    cnt_d   = '0;
                end
            end
            CONFIRM_LO: begin
                // Returning to PRESSED is a bounce, not a new press: no press_accept here.
                if (btn_sync) begin
                    state_d = PRESSED;
                end else if (cnt_q == CntLast) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef STEP_AUTOREPEAT_EN
    localparam int unsigned      HoldW     = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldFirst = HoldW'(HOLD_CYCLES);
    localparam logic [HoldW-1:0] HoldWrap  = HoldW'(HOLD_CYCLES + REPEAT_CYCLES);

    logic [HoldW-1:0] hold_q, hold_d, hold_inc;

    // After the first repeat the counter wraps back to HoldFirst, giving a REPEAT_CYCLES period.
    always_comb begin
        hold_d      = hold_q;
        hold_inc    = hold_q + 1'b1;
        repeat_fire = 1'b0;
        if (state_q == IDLE || press_accept) begin
            hold_d = '0;
        end else if (state_q == PRESSED && state_d == PRESSED) begin
            hold_d = hold_inc;
            if (hold_inc == HoldFirst) begin
                repeat_fire = 1'b1;
            end else if (hold_inc == HoldWrap) begin
                repeat_fire = 1'b1;
                hold_d      = HoldFirst;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic unused_repeat_cfg;

    assign repeat_fire       = 1'b0;
    assign unused_repeat_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};
`endif

    always_comb begin
        stable_d = is_held(state_d);
        x_d      = bus.pulse_mode ? (press_accept | repeat_fire) : stable_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            x_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            x_q      <= x_d;
        end
    end

    assign bus.x      = x_q;
    assign bus.stable = stable_q;
    assign bus.busy   = is_confirm(state_q);

endmodule

// File: tb/tb_step_input_conditioner.sv
// Scoreboard bench for step_input_conditioner (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_CYCLES=8).
// Edge k is the k-th rising edge after the button changes; outputs are sampled 1 ns after it.
module tb_step_input_conditioner;

    typedef struct packed {
        logic x;
        logic stable;
        logic busy;
    } vec_t;

`ifdef STEP_AUTOREPEAT_EN
    localparam bit AutoRepeat = 1'b1;
`else
    localparam bit AutoRepeat = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    vec_t sb_q[$];
    vec_t exp_v;
    vec_t got_v;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    step_input_conditioner_if bus ();

    step_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (16),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic vec_t mk(bit x, bit s, bit b);
        vec_t v;
        v.x      = x;
        v.stable = s;
        v.busy   = b;
        return v;
    endfunction

    function automatic bit in_rng(int k, int lo, int hi);
        return (k >= lo) && (k <= hi);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        got_v = {bus.x, bus.stable, bus.busy};
        n_vec++;
        if (got_v !== 3'b000) begin
            n_err++;
            $display("FAIL reset_assert: x/stable/busy=%b required 000", got_v);
        end
        tick();
        tick();
        #3 rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            sb_q.push_back(mk(0, 0, 0));
            tick();
            exp_v = sb_q.pop_front();
            got_v = {bus.x, bus.stable, bus.busy};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL reset_idle edge %0d: x/stable/busy=%b required %b", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_clean_press();
        bit s;
        for (int k = 1; k <= 32; k++) begin
            bus.btn_raw = (k - 1 < 20);
            s = in_rng(k, 7, 26);
            sb_q.push_back(mk(k == 7, s, in_rng(k, 3, 6) || in_rng(k, 23, 26)));
            tick();
            exp_v = sb_q.pop_front();
            got_v = {bus.x, bus.stable, bus.busy};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL clean_press edge %0d: x/stable/busy=%b required %b", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_glitch_threshold();
        // Four sampled high edges: rejected.
        for (int k = 1; k <= 12; k++) begin
            bus.btn_raw = (k - 1 < 4);
            sb_q.push_back(mk(0, 0, in_rng(k, 3, 6)));
            tick();
            exp_v = sb_q.pop_front();
            got_v = {bus.x, bus.stable, bus.busy};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL glitch_4 edge %0d: x/stable/busy=%b required %b", k, got_v, exp_v);
            end
        end
        // Five sampled high edges: accepted.
        for (int k = 1; k <= 16; k++) begin
            bus.btn_raw = (k - 1 < 5);
            sb_q.push_back(mk(k == 7, in_rng(k, 7, 11), in_rng(k, 3, 6) || in_rng(k, 8, 11)));
            tick();
            exp_v = sb_q.pop_front();
            got_v = {bus.x, bus.stable, bus.busy};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL glitch_5 edge %0d: x/stable/busy=%b required %b", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_bounce(input bit level);
        bit s;
        bit b;
        bus.pulse_mode = !level;
        for (int k = 1; k <= 26; k++) begin
            bus.btn_raw = (k - 1 < 12) || in_rng(k - 1, 14, 15);
            s = in_rng(k, 7, 22);
            b = in_rng(k, 3, 6) || in_rng(k, 15, 16) || in_rng(k, 19, 22);
            sb_q.push_back(mk(level ? s : (k == 7), s, b));
            tick();
            exp_v = sb_q.pop_front();
            got_v = {bus.x, bus.stable, bus.busy};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL bounce_%s edge %0d: x/stable/busy=%b required %b",
                         level ? "level" : "pulse", k, got_v, exp_v);
            end
        end
        bus.pulse_mode = 1'b1;
    endtask

    task automatic test_mode_switch();
        bit s;
        bit xe;
        for (int k = 1; k <= 32; k++) begin
            bus.btn_raw    = (k - 1 < 20);
            bus.pulse_mode = !in_rng(k - 1, 9, 13);
            s  = in_rng(k, 7, 26);
            xe = (k == 7) || (in_rng(k, 10, 14) && s);
            sb_q.push_back(mk(xe, s, in_rng(k, 3, 6) || in_rng(k, 23, 26)));
            tick();
            exp_v = sb_q.pop_front();
            got_v = {bus.x, bus.stable, bus.busy};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL mode_switch edge %0d: x/stable/busy=%b required %b", k, got_v, exp_v);
            end
        end
        bus.pulse_mode = 1'b1;
    endtask

    task automatic test_reset_mid_press();
        bus.btn_raw = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            sb_q.push_back(mk(0, 0, in_rng(k, 3, 4)));
            tick();
            exp_v = sb_q.pop_front();
            got_v = {bus.x, bus.stable, bus.busy};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL pre_reset edge %0d: x/stable/busy=%b required %b", k, got_v, exp_v);
            end
        end
        rst_n = 1'b0;
        #1;
        got_v = {bus.x, bus.stable, bus.busy};
        n_vec++;
        if (got_v !== 3'b000) begin
            n_err++;
            $display("FAIL mid_reset: x/stable/busy=%b required 000", got_v);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            bus.btn_raw = (k - 1 < 12);
            sb_q.push_back(mk(k == 7, in_rng(k, 7, 18), in_rng(k, 3, 6) || in_rng(k, 15, 18)));
            tick();
            exp_v = sb_q.pop_front();
            got_v = {bus.x, bus.stable, bus.busy};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL post_reset edge %0d: x/stable/busy=%b required %b", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_long_hold();
        bit xe;
        for (int k = 1; k <= 50; k++) begin
            bus.btn_raw = (k - 1 < 40);
            xe = (k == 7) || (AutoRepeat && (k == 23 || k == 31 || k == 39));
            sb_q.push_back(mk(xe, in_rng(k, 7, 46), in_rng(k, 3, 6) || in_rng(k, 43, 46)));
            tick();
            exp_v = sb_q.pop_front();
            got_v = {bus.x, bus.stable, bus.busy};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL long_hold edge %0d: x/stable/busy=%b required %b", k, got_v, exp_v);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b1;
        bus.btn_raw    = 1'b0;
        bus.pulse_mode = 1'b1;
        test_reset();
        test_clean_press();
        test_glitch_threshold();
        test_bounce(1'b1);
        test_bounce(1'b0);
        test_mode_switch();
        test_reset_mid_press();
        test_long_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
